// File: rtl/router_fsm_if.sv
// Control-side signal bundle between the router packet FSM and its neighbours
// (packet source, router_sync, router_reg).
interface router_fsm_if #(
    parameter int DATA_W = 8
);
    logic              pkt_valid;
    logic [DATA_W-1:0] data_in;
    logic              fifo_full;
    logic              fifo_empty_0;
    logic              fifo_empty_1;
    logic              fifo_empty_2;
    logic              soft_reset_0;
    logic              soft_reset_1;
    logic              soft_reset_2;
    logic              parity_done;
    logic              low_pkt_valid;

    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              full_state;
    logic              laf_state;
    logic              rst_int_reg;
    logic              write_enb_reg;
    logic              busy;

    // Environment side: drives packet/status inputs, observes FSM controls.
    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, full_state, laf_state,
        input  rst_int_reg, write_enb_reg, busy
    );

    // FSM side.
    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, full_state, laf_state,
        output rst_int_reg, write_enb_reg, busy
    );
endinterface

// File: rtl/router_fsm.sv
// Packet-level control FSM of the 1x3 router: decodes the header address and
// sequences header/payload/parity loading, stalling on full and aborting on soft reset.
module router_fsm #(
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    router_fsm_if.slave  bus
);

    typedef enum logic [2:0] {
        DA  = 3'd0,
        LFD = 3'd1,
        LD  = 3'd2,
        FFS = 3'd3,
        LAF = 3'd4,
        LP  = 3'd5,
        CPE = 3'd6,
        WTE = 3'd7
    } state_e;

    typedef struct packed {
        logic detect_add;
        logic lfd_state;
        logic ld_state;
        logic full_state;
        logic laf_state;
        logic rst_int_reg;
        logic write_enb_reg;
        logic busy;
    } ctrl_t;

    state_e     state, nxt;
    logic [1:0] addr_q;
    ctrl_t      ctrl_q;

    logic [1:0] hdr_addr;
    logic       hdr_ok;
    logic       empty_hdr;
    logic       empty_sel;
    logic       abort;
    logic       unused_data_hi;

    assign hdr_addr       = bus.data_in[1:0];
    assign hdr_ok         = bus.pkt_valid && (hdr_addr != 2'd3);
    assign unused_data_hi = ^bus.data_in[DATA_W-1:2];

    function automatic logic pick3(input logic [1:0] sel, input logic a0,
                                   input logic a1, input logic a2);
        case (sel)
            2'd0:    return a0;
            2'd1:    return a1;
            2'd2:    return a2;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ctrl_t decode(input state_e s);
        ctrl_t c;
        c               = '0;
        c.detect_add    = (s == DA);
        c.lfd_state     = (s == LFD);
        c.ld_state      = (s == LD);
        c.full_state    = (s == FFS);
        c.laf_state     = (s == LAF);
        c.rst_int_reg   = (s == CPE);
        c.write_enb_reg = (s == LD) || (s == LP) || (s == LAF);
        c.busy          = !((s == DA) || (s == LD));
        return c;
    endfunction

    assign empty_hdr = pick3(hdr_addr, bus.fifo_empty_0, bus.fifo_empty_1, bus.fifo_empty_2);
    assign empty_sel = pick3(addr_q, bus.fifo_empty_0, bus.fifo_empty_1, bus.fifo_empty_2);
    assign abort     = (state != DA) &&
                       pick3(addr_q, bus.soft_reset_0, bus.soft_reset_1, bus.soft_reset_2);

    // NOTE: nxt gets a default before the case so every path assigns it and no latch is inferred.
    always_comb begin
        nxt = state;
        if (abort) begin
            nxt = DA;
        end else begin
            case (state)
                DA:  if (hdr_ok) nxt = empty_hdr ? LFD : WTE;
                LFD: nxt = LD;
                LD: begin
                    if (bus.fifo_full)       nxt = FFS;
                    else if (!bus.pkt_valid) nxt = LP;
                end
                FFS: if (!bus.fifo_full) nxt = LAF;
                LAF: begin
                    if (bus.parity_done)        nxt = DA;
                    else if (bus.low_pkt_valid) nxt = LP;
                    else                        nxt = LD;
                end
                LP:  nxt = CPE;
                CPE: nxt = bus.fifo_full ? FFS : DA;
                WTE: if (empty_sel) nxt = LFD;
                default: nxt = DA;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    // NOTE: state registers use non-blocking assignments so all updates share the same clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= DA;
            addr_q <= 2'd0;
            ctrl_q <= decode(DA);
        end else begin
            state  <= nxt;
            ctrl_q <= decode(nxt);
            if (state == DA && hdr_ok) addr_q <= hdr_addr;
        end
    end

    assign bus.detect_add    = ctrl_q.detect_add;
    assign bus.lfd_state     = ctrl_q.lfd_state;
    assign bus.ld_state      = ctrl_q.ld_state;
    assign bus.full_state    = ctrl_q.full_state;
    assign bus.laf_state     = ctrl_q.laf_state;
    assign bus.rst_int_reg   = ctrl_q.rst_int_reg;
    assign bus.write_enb_reg = ctrl_q.write_enb_reg;
    assign bus.busy          = ctrl_q.busy;

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: walks packet flows and checks the Moore
// control outputs against hand-derived per-state values.
module tb_router_fsm;

    typedef enum int {S_DA, S_LFD, S_LD, S_FFS, S_LAF, S_LP, S_CPE, S_WTE} st_e;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    router_fsm_if #(.DATA_W(8)) bus ();

    router_fsm #(.DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {detect_add, lfd, ld, full, laf, rst_int_reg, write_enb_reg, busy}
    function automatic logic [7:0] exp_out(input st_e s);
        case (s)
            S_DA:    return 8'b1000_0000;
            S_LFD:   return 8'b0100_0001;
            S_LD:    return 8'b0010_0010;
            S_FFS:   return 8'b0001_0001;
            S_LAF:   return 8'b0000_1011;
            S_LP:    return 8'b0000_0011;
            S_CPE:   return 8'b0000_0101;
            default: return 8'b0000_0001;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic step_expect(input string tag, input st_e s);
        logic [7:0] outs;
        @(posedge clk);
        #1;
        outs = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.full_state,
                bus.laf_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};
        check(tag, outs, exp_out(s));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.pkt_valid     = 1'b0;
        bus.data_in       = 8'h00;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty_0  = 1'b1;
        bus.fifo_empty_1  = 1'b1;
        bus.fifo_empty_2  = 1'b1;
        bus.soft_reset_0  = 1'b0;
        bus.soft_reset_1  = 1'b0;
        bus.soft_reset_2  = 1'b0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;

        step_expect("reset", S_DA);
        rst = 1'b0;
        step_expect("idle", S_DA);

        // Normal packet to port 1: DA,LFD,LD,LD,LD,LP,CPE,DA
        bus.pkt_valid = 1'b1;
        bus.data_in   = 8'h05;
        step_expect("p1_lfd", S_LFD);
        bus.data_in   = 8'hA7;
        step_expect("p1_ld0", S_LD);
        step_expect("p1_ld1", S_LD);
        step_expect("p1_ld2", S_LD);
        bus.pkt_valid = 1'b0;
        step_expect("p1_lp", S_LP);
        step_expect("p1_cpe", S_CPE);
        step_expect("p1_da", S_DA);

        // Port 2 busy: WTE held while FIFO2 not empty; data_in changes show addr_q is used
        bus.pkt_valid    = 1'b1;
        bus.data_in      = 8'h02;
        bus.fifo_empty_2 = 1'b0;
        step_expect("wte0", S_WTE);
        bus.data_in      = 8'h00;
        step_expect("wte1", S_WTE);
        step_expect("wte2", S_WTE);
        step_expect("wte3", S_WTE);
        bus.fifo_empty_2 = 1'b1;
        step_expect("wte_lfd", S_LFD);
        step_expect("wte_ld", S_LD);

        // Full stall: FFS x3, LAF, back to LD
        bus.fifo_full = 1'b1;
        step_expect("ffs0", S_FFS);
        step_expect("ffs1", S_FFS);
        step_expect("ffs2", S_FFS);
        bus.fifo_full = 1'b0;
        step_expect("laf", S_LAF);
        step_expect("laf_ld", S_LD);

        // fifo_full beats !pkt_valid in LD; LAF with low_pkt_valid -> LP
        bus.fifo_full = 1'b1;
        bus.pkt_valid = 1'b0;
        step_expect("ld_prio", S_FFS);
        bus.fifo_full = 1'b0;
        step_expect("laf2", S_LAF);
        bus.low_pkt_valid = 1'b1;
        step_expect("laf_lp", S_LP);
        bus.low_pkt_valid = 1'b0;
        step_expect("lp_cpe", S_CPE);
        bus.fifo_full = 1'b1;
        step_expect("cpe_ffs", S_FFS);
        bus.fifo_full = 1'b0;
        step_expect("laf3", S_LAF);
        bus.parity_done = 1'b1;
        step_expect("laf_da", S_DA);
        bus.parity_done = 1'b0;

        // Illegal address 3 is dropped
        bus.pkt_valid = 1'b1;
        bus.data_in   = 8'h03;
        step_expect("addr3_a", S_DA);
        step_expect("addr3_b", S_DA);

        // Soft reset: other port ignored, selected port aborts
        bus.data_in = 8'h00;
        step_expect("sr_lfd", S_LFD);
        step_expect("sr_ld", S_LD);
        bus.soft_reset_1 = 1'b1;
        step_expect("sr_other", S_LD);
        bus.soft_reset_1 = 1'b0;
        bus.soft_reset_0 = 1'b1;
        step_expect("sr_abort", S_DA);
        bus.soft_reset_0 = 1'b0;

        // Abort out of WTE on port 1
        bus.data_in      = 8'h01;
        bus.fifo_empty_1 = 1'b0;
        step_expect("sr_wte", S_WTE);
        bus.soft_reset_1 = 1'b1;
        step_expect("sr_wte_da", S_DA);
        bus.soft_reset_1 = 1'b0;
        bus.fifo_empty_1 = 1'b1;

        // Reset while stalled in FFS
        bus.data_in = 8'h02;
        step_expect("r_lfd", S_LFD);
        step_expect("r_ld", S_LD);
        bus.fifo_full = 1'b1;
        step_expect("r_ffs", S_FFS);
        rst = 1'b1;
        step_expect("r_da", S_DA);
        rst = 1'b0;
        bus.fifo_full = 1'b0;
        bus.pkt_valid = 1'b0;
        step_expect("r_idle", S_DA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
